rc4_ksa: RTL and testbench
==========================

Name: rc4_ksa

Overview:
- RC4 key-scheduling engine; consumes the 24-bit key held in the HPS-written key register.
- Initialises and permutes the 256-byte S-box in an external single-port on-chip RAM.
- Start/busy/done handshake to the HPS control logic.
- Downstream PRGA/decrypt stage reads the finished S-box once done is high.

Parameters:
- KEY_BYTES, 3, number of key bytes; key width is 8*KEY_BYTES.
- N, 256, S-box size; mem address width is log2(N)=8.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- key  in  24  key; key[23:16] is key byte 0, key[7:0] is key byte 2
- busy  out  1  high while a schedule is running
- done  out  1  high from completion until the next accepted start
- mem_addr  out  8  S-box RAM address
- mem_wrdata  out  8  S-box RAM write data
- mem_wren  out  1  S-box RAM write enable
- mem_rddata  in  8  S-box RAM read data; valid the cycle after mem_addr is presented (1-cycle read latency)

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Registered outputs: all outputs are registered.
- Reset values: busy=0, done=0, mem_wren=0, mem_addr=0, mem_wrdata=0. Internal i=0, j=0, kidx=0, state=IDLE.
- IDLE:
  - On start=1: latch key into key_q; clear i, j, kidx and done; set busy=1; go to INIT.
  - Key changes after acceptance are ignored.
- INIT (one cycle per entry):
  - Drive mem_addr=i, mem_wrdata=i, mem_wren=1; then i++.
  - After i=255, i wraps to 0 and the FSM goes to RD_I. 256 cycles total.
- Swap loop, six cycles per i:
  - RD_I: mem_addr=i, wren=0.
  - LAT_I: si<=mem_rddata; j<=j+mem_rddata+keybyte[kidx], mod 256.
  - RD_J: mem_addr=j.
  - LAT_J: sj<=mem_rddata.
  - WR_I: mem_addr=i, wrdata=sj, wren=1.
  - WR_J: mem_addr=j, wrdata=si, wren=1.
  - After WR_J: kidx wraps KEY_BYTES-1 to 0; i++. If i was 255, go to FIN, else RD_I.
- FIN: busy=0, done=1; go to IDLE. done stays high until the next accepted start.
- Latency: done rises 1+256+1536 = 1793 clock edges after the edge that accepts start.
- mem_wren is high only in INIT, WR_I and WR_J.
- Boundary conditions:
  - i==j: WR_I writes sj (equal to si), then WR_J writes si; net no-op, as required.
  - j wraps modulo 256 (8-bit adder, carries discarded).
  - start while busy is ignored; start high in FIN is not accepted until IDLE.
  - start held high continuously restarts the schedule on each IDLE visit.
  - reset mid-run: returns to IDLE with reset values; RAM contents are undefined, and the next start fully reinitialises.

Decomposition:
- rc4_pkg holds:
  - state enum (IDLE, INIT, RD_I, LAT_I, RD_J, LAT_J, WR_I, WR_J, FIN)
  - constants N=256, SBOX_AW=8, KEY_BYTES=3
  - the key-byte select function (byte kidx, MSB first)
- Single module; no sub-module needed. The FSM, counters and datapath fit in one file.

Test Plan:
- Bench setup: 256x8 RAM model with 1-cycle read latency, plus a C/behavioural KSA reference model.
- Reset values: assert reset for 3 cycles, no start -> busy=0, done=0, mem_wren=0, mem_addr=0 every cycle.
- Zero key: key=0x000000, 1-cycle start pulse -> busy rises next edge; done high exactly 1793 edges later; RAM equals the model's S for key 00 00 00 (S[0]=0x00, S[1]=0x23 from model; all 256 bytes compared).
- ASCII key: key=0x4B6579 ("Key") -> RAM matches the model. A follow-on PRGA check on the final S gives keystream EB 9F 77 81 for the first 4 bytes.
- start while busy: pulse start with key=0x123456, then at cycle 500 pulse start with key=0xFFFFFF -> second start ignored; result matches the model for 0x123456; done still at 1793.
- Reset mid-run: start key=0x010203, assert reset at cycle 900 -> next edge busy=0, wren=0. Restart with key=0x010203 -> RAM matches the model and done at 1793 after the new start.
- Back-to-back runs: after done, start with key=0xA5A5A5 -> done drops on the accepting edge; INIT rewrites S[k]=k for all 256 entries (checked via write monitor); final RAM matches the model.

Source files
------------

// File: rtl/rc4_ksa_pkg.sv
// Shared constants, FSM state encoding and key-byte selection for the RC4 key scheduler.
package rc4_ksa_pkg;

  localparam int unsigned N         = 256;
  localparam int unsigned SBOX_AW   = 8;
  localparam int unsigned KEY_BYTES = 3;
  localparam int unsigned KEY_W     = 8 * KEY_BYTES;
  localparam int unsigned KIDX_W    = $clog2(KEY_BYTES);

  localparam logic [SBOX_AW-1:0] SBOX_LAST = SBOX_AW'(N - 1);
  localparam logic [KIDX_W-1:0]  KIDX_LAST = KIDX_W'(KEY_BYTES - 1);

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    RD_I,
    LAT_I,
    RD_J,
    LAT_J,
    WR_I,
    WR_J,
    FIN
  } state_t;

  // Byte 0 is the most significant byte of the key word.
  function automatic logic [7:0] key_byte(input logic [KEY_W-1:0]  key,
                                          input logic [KIDX_W-1:0] kidx);
    return key[8 * (KEY_BYTES - 1 - 32'(kidx)) +: 8];
  endfunction

endpackage

// File: rtl/rc4_ksa_if.sv
// Control handshake and S-box RAM port between the key scheduler and its host/RAM.
interface rc4_ksa_if;
  import rc4_ksa_pkg::*;

  logic               start;
  logic [KEY_W-1:0]   key;
  logic               busy;
  logic               done;
  logic [SBOX_AW-1:0] mem_addr;
  logic [SBOX_AW-1:0] mem_wrdata;
  logic               mem_wren;
  logic [SBOX_AW-1:0] mem_rddata;

  modport master (
    output start, key, mem_rddata,
    input  busy, done, mem_addr, mem_wrdata, mem_wren
  );

  modport slave (
    input  start, key, mem_rddata,
    output busy, done, mem_addr, mem_wrdata, mem_wren
  );

endinterface

// File: rtl/rc4_ksa.sv
// RC4 key-scheduling engine: initialises and permutes a 256-byte S-box held in external single-port RAM.
module rc4_ksa
  import rc4_ksa_pkg::*;
(
  input logic       clk,
  input logic       reset,
  rc4_ksa_if.slave  bus
);

  state_t              state_q, state_d;
  logic [SBOX_AW-1:0]  i_q, i_d;
  logic [SBOX_AW-1:0]  j_q, j_d;
  logic [SBOX_AW-1:0]  si_q, si_d;
  logic [SBOX_AW-1:0]  sj_q, sj_d;
  logic [KIDX_W-1:0]   kidx_q, kidx_d;
  logic [KEY_W-1:0]    key_q, key_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                wren_q, wren_d;
  logic [SBOX_AW-1:0]  addr_q, addr_d;
  logic [SBOX_AW-1:0]  wrdata_q, wrdata_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      i_q      <= '0;
      j_q      <= '0;
      si_q     <= '0;
      sj_q     <= '0;
      kidx_q   <= '0;
      key_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wren_q   <= 1'b0;
      addr_q   <= '0;
      wrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      si_q     <= si_d;
      sj_q     <= sj_d;
      kidx_q   <= kidx_d;
      key_q    <= key_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wren_q   <= wren_d;
      addr_q   <= addr_d;
      wrdata_q <= wrdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    si_d     = si_q;
    sj_d     = sj_q;
    kidx_d   = kidx_q;
    key_d    = key_q;
    busy_d   = busy_q;
    done_d   = done_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          key_d   = bus.key;
          i_d     = '0;
          j_d     = '0;
          kidx_d  = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = INIT;
        end
      end
      INIT: begin
        i_d = i_q + 1'b1;
        if (i_q == SBOX_LAST) state_d = RD_I;
      end
      RD_I:  state_d = LAT_I;
      LAT_I: begin
        si_d    = bus.mem_rddata;
        j_d     = j_q + bus.mem_rddata + key_byte(key_q, kidx_q);
        state_d = RD_J;
      end
      RD_J:  state_d = LAT_J;
      LAT_J: begin
        sj_d    = bus.mem_rddata;
        state_d = WR_I;
      end
      WR_I:  state_d = WR_J;
      WR_J: begin
        kidx_d  = (kidx_q == KIDX_LAST) ? '0 : kidx_q + 1'b1;
        i_d     = i_q + 1'b1;
        state_d = (i_q == SBOX_LAST) ? FIN : RD_I;
      end
      FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // RAM port is driven from the state being entered, so the registered
    // address/data are on the bus for the whole cycle of that state and a
    // read issued in RD_x returns its data during the following LAT_x.
    addr_d   = addr_q;
    wrdata_d = wrdata_q;
    wren_d   = 1'b0;
    case (state_d)
      INIT: begin
        addr_d   = i_d;
        wrdata_d = i_d;
        wren_d   = 1'b1;
      end
      RD_I: addr_d = i_d;
      RD_J: addr_d = j_d;
      WR_I: begin
        addr_d   = i_d;
        wrdata_d = sj_d;
        wren_d   = 1'b1;
      end
      WR_J: begin
        addr_d   = j_d;
        wrdata_d = si_d;
        wren_d   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.mem_wren   = wren_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wrdata = wrdata_q;

endmodule

// File: tb/tb_rc4_ksa.sv
// Directed self-checking bench for rc4_ksa: RAM model with 1-cycle read latency plus a behavioural KSA reference.
module tb_rc4_ksa;
  import rc4_ksa_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rc4_ksa_if bus ();

  rc4_ksa dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (bus.mem_wren) ram[bus.mem_addr] <= bus.mem_wrdata;
    bus.mem_rddata <= ram[bus.mem_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] ref_s [256];

  task automatic ksa_model(input logic [23:0] k);
    logic [7:0] kb [3];
    logic [7:0] t;
    int j;
    kb[0] = k[23:16];
    kb[1] = k[15:8];
    kb[2] = k[7:0];
    for (int i = 0; i < 256; i++) ref_s[i] = 8'(i);
    j = 0;
    for (int i = 0; i < 256; i++) begin
      j = (j + int'(ref_s[i]) + int'(kb[i % 3])) % 256;
      t = ref_s[i];
      ref_s[i] = ref_s[j];
      ref_s[j] = t;
    end
  endtask

  task automatic launch(input logic [23:0] k, input bit hold);
    @(negedge clk);
    bus.key   = k;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
  endtask

  // edges = edge count at which done was seen, -1 on timeout, -2 after a planted reset
  task automatic wait_done(input int n0, input int poke_at, input logic [23:0] poke_key,
                           input int reset_at, output int edges);
    int n;
    n = n0;
    edges = -1;
    while (n < 4000) begin
      if (n == poke_at) begin
        bus.key   = poke_key;
        bus.start = 1'b1;
      end
      if (n == reset_at) reset = 1'b1;
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == poke_at + 1) bus.start = 1'b0;
      if (n == reset_at + 1) begin
        edges = -2;
        return;
      end
      if (bus.done) begin
        edges = n;
        return;
      end
    end
  endtask

  task automatic test_reset();
    logic [10:0] obs;
    bus.start = 1'b0;
    bus.key   = '0;
    reset     = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      obs = {bus.busy, bus.done, bus.mem_wren, bus.mem_addr};
      n_cmp++;
      if (obs !== 11'b0) begin
        n_bad++;
        $display("FAIL reset_idle[%0d]: {busy,done,wren,addr} got %h expected 000", c, obs);
      end
    end
  endtask

  task automatic test_zero_key();
    int edges;
    ksa_model(24'h000000);
    launch(24'h000000, 1'b0);
    n_cmp++;
    if ({bus.busy, bus.done} !== 2'b10) begin
      n_bad++;
      $display("FAIL zero_accept: {busy,done} got %b expected 10", {bus.busy, bus.done});
    end
    wait_done(0, -1, 24'h0, -1, edges);
    n_cmp++;
    if (edges !== 1793) begin
      n_bad++;
      $display("FAIL zero_latency: done after %0d edges expected 1793", edges);
    end
    n_cmp++;
    if ({bus.busy, bus.done} !== 2'b01) begin
      n_bad++;
      $display("FAIL zero_done: {busy,done} got %b expected 01", {bus.busy, bus.done});
    end
    for (int a = 0; a < 256; a++) begin
      n_cmp++;
      if (ram[a] !== ref_s[a]) begin
        n_bad++;
        $display("FAIL zero_sbox[%0d]: got %02h expected %02h", a, ram[a], ref_s[a]);
      end
    end
  endtask

  task automatic test_ascii_key();
    int edges;
    logic [7:0] s [256];
    logic [7:0] exp_ks [4];
    logic [7:0] t, pi, pj, ks;
    exp_ks = '{8'hEB, 8'h9F, 8'h77, 8'h81};
    ksa_model(24'h4B6579);
    launch(24'h4B6579, 1'b0);
    wait_done(0, -1, 24'h0, -1, edges);
    n_cmp++;
    if (edges !== 1793) begin
      n_bad++;
      $display("FAIL ascii_latency: done after %0d edges expected 1793", edges);
    end
    for (int a = 0; a < 256; a++) begin
      s[a] = ram[a];
      n_cmp++;
      if (ram[a] !== ref_s[a]) begin
        n_bad++;
        $display("FAIL ascii_sbox[%0d]: got %02h expected %02h", a, ram[a], ref_s[a]);
      end
    end
    pi = 8'h00;
    pj = 8'h00;
    for (int b = 0; b < 4; b++) begin
      pi = pi + 8'd1;
      pj = pj + s[pi];
      t = s[pi];
      s[pi] = s[pj];
      s[pj] = t;
      ks = s[8'(s[pi] + s[pj])];
      n_cmp++;
      if (ks !== exp_ks[b]) begin
        n_bad++;
        $display("FAIL ascii_keystream[%0d]: got %02h expected %02h", b, ks, exp_ks[b]);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int edges;
    ksa_model(24'h123456);
    launch(24'h123456, 1'b0);
    wait_done(0, 500, 24'hFFFFFF, -1, edges);
    n_cmp++;
    if (edges !== 1793) begin
      n_bad++;
      $display("FAIL busy_latency: done after %0d edges expected 1793", edges);
    end
    for (int a = 0; a < 256; a++) begin
      n_cmp++;
      if (ram[a] !== ref_s[a]) begin
        n_bad++;
        $display("FAIL busy_sbox[%0d]: got %02h expected %02h", a, ram[a], ref_s[a]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int edges;
    ksa_model(24'h010203);
    launch(24'h010203, 1'b0);
    wait_done(0, -1, 24'h0, 900, edges);
    n_cmp++;
    if (edges !== -2) begin
      n_bad++;
      $display("FAIL midreset_reach: wait ended with %0d expected -2", edges);
    end
    n_cmp++;
    if ({bus.busy, bus.done, bus.mem_wren} !== 3'b000) begin
      n_bad++;
      $display("FAIL midreset_state: {busy,done,wren} got %b expected 000",
               {bus.busy, bus.done, bus.mem_wren});
    end
    reset = 1'b0;
    launch(24'h010203, 1'b0);
    wait_done(0, -1, 24'h0, -1, edges);
    n_cmp++;
    if (edges !== 1793) begin
      n_bad++;
      $display("FAIL midreset_latency: done after %0d edges expected 1793", edges);
    end
    for (int a = 0; a < 256; a++) begin
      n_cmp++;
      if (ram[a] !== ref_s[a]) begin
        n_bad++;
        $display("FAIL midreset_sbox[%0d]: got %02h expected %02h", a, ram[a], ref_s[a]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int edges;
    logic [16:0] obs, exp_w;
    ksa_model(24'hA5A5A5);
    n_cmp++;
    if (bus.done !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_prior_done: got %b expected 1", bus.done);
    end
    launch(24'hA5A5A5, 1'b0);
    n_cmp++;
    if (bus.done !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_done_drop: got %b expected 0", bus.done);
    end
    for (int k = 0; k < 256; k++) begin
      if (k != 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      obs   = {bus.mem_wren, bus.mem_addr, bus.mem_wrdata};
      exp_w = {1'b1, 8'(k), 8'(k)};
      n_cmp++;
      if (obs !== exp_w) begin
        n_bad++;
        $display("FAIL b2b_init[%0d]: {wren,addr,data} got %h expected %h", k, obs, exp_w);
      end
    end
    wait_done(255, -1, 24'h0, -1, edges);
    n_cmp++;
    if (edges !== 1793) begin
      n_bad++;
      $display("FAIL b2b_latency: done after %0d edges expected 1793", edges);
    end
    for (int a = 0; a < 256; a++) begin
      n_cmp++;
      if (ram[a] !== ref_s[a]) begin
        n_bad++;
        $display("FAIL b2b_sbox[%0d]: got %02h expected %02h", a, ram[a], ref_s[a]);
      end
    end
  endtask

  task automatic test_start_held();
    int edges;
    launch(24'h0F1E2D, 1'b1);
    wait_done(0, -1, 24'h0, -1, edges);
    n_cmp++;
    if (edges !== 1793) begin
      n_bad++;
      $display("FAIL held_latency: done after %0d edges expected 1793", edges);
    end
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.done} !== 2'b10) begin
      n_bad++;
      $display("FAIL held_restart: {busy,done} got %b expected 10", {bus.busy, bus.done});
    end
    bus.start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero_key();
    test_ascii_key();
    test_start_while_busy();
    test_reset_mid_run();
    test_back_to_back();
    test_start_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
